ex_hazard_ctrl: RTL and testbench

//  Sequencing/forwarding controller for the execute-phase ALU datapath.
//  - Tracks destination registers of instructions in EX, EX/MEM and MEM/WB.
//  - Drives the ALU operand-select muxes mux1/mux2/mux3 and alu_op.
//  - Inserts load-use bubbles and stalls decode, so the datapath always sees consistent operands.
//  - Sits between decode (ID) and execute_phase.

---
 rtl/ex_pkg.sv | 31 +++
 rtl/ex_fwd_sel.sv | 47 ++++
 rtl/ex_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute-phase hazard/forwarding controller:
//   REG_AW / OP_W      register-address and ALU-opcode widths
//   MUX_*              operand-select encodings driven onto mux1/mux2
//   ALU_NOP            opcode presented to the ALU on a bubble
//   track_ent_t        one pipeline tracking entry {valid, rd, we, is_load}
// ---------------------------------------------------------------------------
package ex_pkg;

    localparam int REG_AW = 5;
    localparam int OP_W   = 5;

    localparam logic [1:0] MUX_RS    = 2'b00;
    localparam logic [1:0] MUX_MEMWB = 2'b01;
    localparam logic [1:0] MUX_EXMEM = 2'b10;
    localparam logic [1:0] MUX_ZERO  = 2'b11;

    localparam logic [OP_W-1:0] ALU_NOP = 5'b00000;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } track_ent_t;

    // An empty slot: what a bubble or a reset leaves behind.
    localparam track_ent_t TRK_EMPTY = '{valid: 1'b0, rd: '0, we: 1'b0, is_load: 1'b0};

endpackage : ex_pkg

// File: rtl/ex_fwd_sel.sv
// ---------------------------------------------------------------------------
// ex_fwd_sel
// Combinational forwarding selector for one source operand of the instruction
// currently in decode.
//   src_i        source register address
//   use_i        instruction actually reads this source
//   ex_ent_i     tracking entry of the instruction now in EX
//   mem_valid_i  MEM (EX/MEM) entry valid
//   mem_rd_i     MEM entry destination
//   mem_we_i     MEM entry writes its destination
//   sel_o        operand select (MUX_RS / MUX_MEMWB / MUX_EXMEM / MUX_ZERO)
//   hit_load_o   the newest producer of src is a load still in EX
// ---------------------------------------------------------------------------
module ex_fwd_sel
    import ex_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_i,
    input  track_ent_t        ex_ent_i,
    input  logic              mem_valid_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_we_i,
    output logic [1:0]        sel_o,
    output logic              hit_load_o
);

    always_comb begin
        sel_o      = MUX_RS;
        hit_load_o = 1'b0;
        if (use_i) begin
            if (src_i == '0) begin
                // x0 is hard zero: never forwarded, never a load-use hazard.
                sel_o = MUX_ZERO;
            end else if (ex_ent_i.valid && ex_ent_i.is_load && (ex_ent_i.rd == src_i)) begin
                // Load data is not available until MEM/WB; the select is
                // irrelevant because the top inserts a bubble instead.
                hit_load_o = 1'b1;
            end else if (ex_ent_i.valid && ex_ent_i.we && (ex_ent_i.rd == src_i)) begin
                // EX is checked before MEM so the newest producer wins.
                sel_o = MUX_EXMEM;
            end else if (mem_valid_i && mem_we_i && (mem_rd_i == src_i)) begin
                sel_o = MUX_MEMWB;
            end
        end
    end

endmodule : ex_fwd_sel

// File: rtl/ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl
// Sequencing/forwarding controller between decode and the execute-phase ALU.
// Tracks the destinations of the instructions in EX, EX/MEM and MEM/WB,
// drives the operand-select muxes and alu_op, and inserts load-use bubbles.
//   clk, rst          clock, synchronous active-high reset
//   id_*_i            instruction presented by decode
//   id_ready_o        decode instruction accepted this cycle (combinational)
//   mem_stall_i       freeze all tracking and registered outputs
//   flush_i           branch redirect: ID instruction dropped, next EX bubble
//   ex_valid_o        EX holds a real instruction
//   alu_op_o          ALU operation (ALU_NOP on a bubble)
//   mux1_o / mux2_o   operand1 / operand2 select
//   mux3_o            immediate replaces operand2
//   stall_cnt_o       saturating count of cycles decode was held off
// All outputs except id_ready_o are registered and change on the edge where
// execute captures its operands.
// ---------------------------------------------------------------------------
module ex_hazard_ctrl
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_use_imm_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_we_i,
    input  logic              id_is_load_i,
    input  logic [OP_W-1:0]   id_alu_op_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [OP_W-1:0]   alu_op_o,
    output logic [1:0]        mux1_o,
    output logic [1:0]        mux2_o,
    output logic              mux3_o,
    output logic [31:0]       stall_cnt_o
);

    localparam int N_SRC   = 2;
    localparam int N_TRK   = 3;
    localparam int TRK_EX  = 0;
    localparam int TRK_MEM = 1;

    // Tracking entries: index 0 = EX, 1 = EX/MEM, 2 = MEM/WB.
    track_ent_t trk_q     [N_TRK];
    track_ent_t trk_d     [N_TRK];
    track_ent_t trk_shift [N_TRK];

    logic              ex_valid_q, ex_valid_d;
    logic [OP_W-1:0]   alu_op_q,   alu_op_d;
    logic [1:0]        mux1_q,     mux1_d;
    logic [1:0]        mux2_q,     mux2_d;
    logic              mux3_q,     mux3_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic [REG_AW-1:0] src      [N_SRC];
    logic              src_use  [N_SRC];
    logic [1:0]        sel      [N_SRC];
    logic              hit_load [N_SRC];

    logic              load_use;
    logic              id_ready;
    logic              accept;
    track_ent_t        id_ent;

    assign src[0]     = id_rs1_i;
    assign src[1]     = id_rs2_i;
    assign src_use[0] = id_use_rs1_i;
    assign src_use[1] = id_use_rs2_i;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fwd
            ex_fwd_sel u_fwd_sel (
                .src_i       (src[gi]),
                .use_i       (src_use[gi]),
                .ex_ent_i    (trk_q[TRK_EX]),
                .mem_valid_i (trk_q[TRK_MEM].valid),
                .mem_rd_i    (trk_q[TRK_MEM].rd),
                .mem_we_i    (trk_q[TRK_MEM].we),
                .sel_o       (sel[gi]),
                .hit_load_o  (hit_load[gi])
            );
        end
    endgenerate

    // A hazard only matters when decode actually presents an instruction.
    assign load_use   = id_valid_i & (hit_load[0] | hit_load[1]);
    assign id_ready   = ~rst & ~mem_stall_i & ~load_use & ~flush_i;
    assign id_ready_o = id_ready;
    assign accept     = id_valid_i & id_ready;

    assign id_ent = '{valid: 1'b1, rd: id_rd_i, we: id_rd_we_i, is_load: id_is_load_i};

    // Shifted view of the pipe: new EX is the accepted instruction or a
    // bubble; the instruction leaving EX (e.g. the redirecting branch itself)
    // and older entries keep moving even on a flush.
    assign trk_shift[0] = accept ? id_ent : TRK_EMPTY;
    generate
        for (genvar gi = 1; gi < N_TRK; gi++) begin : g_shift
            assign trk_shift[gi] = trk_q[gi-1];
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < N_TRK; k++) begin
            trk_d[k] = mem_stall_i ? trk_q[k] : trk_shift[k];
        end
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        alu_op_d    = alu_op_q;
        mux1_d      = mux1_q;
        mux2_d      = mux2_q;
        mux3_d      = mux3_q;
        stall_cnt_d = stall_cnt_q;

        if (id_valid_i && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        if (!mem_stall_i) begin
            if (accept) begin
                ex_valid_d = 1'b1;
                alu_op_d   = id_alu_op_i;
                mux1_d     = sel[0];
                mux2_d     = sel[1];
                mux3_d     = id_use_imm_i;
            end else begin
                ex_valid_d = 1'b0;
                alu_op_d   = ALU_NOP;
                mux1_d     = MUX_ZERO;
                mux2_d     = MUX_ZERO;
                mux3_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TRK; k++) begin
                trk_q[k] <= TRK_EMPTY;
            end
            ex_valid_q  <= 1'b0;
            alu_op_q    <= ALU_NOP;
            mux1_q      <= MUX_ZERO;
            mux2_q      <= MUX_ZERO;
            mux3_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < N_TRK; k++) begin
                trk_q[k] <= trk_d[k];
            end
            ex_valid_q  <= ex_valid_d;
            alu_op_q    <= alu_op_d;
            mux1_q      <= mux1_d;
            mux2_q      <= mux2_d;
            mux3_q      <= mux3_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o  = ex_valid_q;
    assign alu_op_o    = alu_op_q;
    assign mux1_o      = mux1_q;
    assign mux2_o      = mux2_q;
    assign mux3_o      = mux3_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule : ex_hazard_ctrl

// File: tb/tb_ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_hazard_ctrl
// Directed scenarios followed by a randomized run, all checked against a
// reference model that keeps the in-flight instructions as a small list
// (newest first) and answers "who produces this register" by searching it.
// ---------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, id_use_imm_i;
    logic        id_rd_we_i, id_is_load_i;
    logic [4:0]  id_alu_op_i;
    logic        mem_stall_i, flush_i;
    logic        ex_valid_o;
    logic [4:0]  alu_op_o;
    logic [1:0]  mux1_o, mux2_o;
    logic        mux3_o;
    logic [31:0] stall_cnt_o;

    always #5 clk = ~clk;

    ex_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid_i),
        .id_ready_o   (id_ready_o),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .id_use_imm_i (id_use_imm_i),
        .id_rd_i      (id_rd_i),
        .id_rd_we_i   (id_rd_we_i),
        .id_is_load_i (id_is_load_i),
        .id_alu_op_i  (id_alu_op_i),
        .mem_stall_i  (mem_stall_i),
        .flush_i      (flush_i),
        .ex_valid_o   (ex_valid_o),
        .alu_op_o     (alu_op_o),
        .mux1_o       (mux1_o),
        .mux2_o       (mux2_o),
        .mux3_o       (mux3_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---- reference model --------------------------------------------------
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } m_ent_t;

    m_ent_t      m_pipe [3];     // [0] newest (EX), [1] MEM, [2] WB
    logic        m_ex_valid;
    logic [4:0]  m_op;
    logic [1:0]  m_m1, m_m2;
    logic        m_m3;
    logic [31:0] m_cnt;
    logic        obs_ready;

    // Newest in-flight writer of s decides the select; a load still in EX
    // cannot supply data yet and is reported as a hazard.
    function automatic logic [1:0] m_fwd(input logic [4:0] s, input logic u, output logic haz);
        haz = 1'b0;
        if (!u) return 2'b00;
        if (s == 5'd0) return 2'b11;
        for (int k = 0; k < 2; k++) begin
            if (m_pipe[k].v && m_pipe[k].we && m_pipe[k].rd == s) begin
                if (k == 0 && m_pipe[k].ld) begin
                    haz = 1'b1;
                    return 2'b00;
                end
                return (k == 0) ? 2'b10 : 2'b01;
            end
        end
        return 2'b00;
    endfunction

    function automatic logic m_ready();
        logic h1, h2;
        logic [1:0] s1, s2;
        s1 = m_fwd(id_rs1_i, id_use_rs1_i, h1);
        s2 = m_fwd(id_rs2_i, id_use_rs2_i, h2);
        if (rst || mem_stall_i || flush_i) return 1'b0;
        if (id_valid_i && (h1 || h2)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) m_pipe[k] = '{v: 0, rd: 0, we: 0, ld: 0};
        m_ex_valid = 1'b0;
        m_op       = 5'd0;
        m_m1       = 2'b11;
        m_m2       = 2'b11;
        m_m3       = 1'b0;
        m_cnt      = 32'd0;
    endtask

    // Applies the inputs present at the clock edge to the model.
    task automatic m_clock();
        logic rdy, h1, h2;
        logic [1:0] s1, s2;
        if (rst) begin
            m_reset();
            return;
        end
        rdy = m_ready();
        s1  = m_fwd(id_rs1_i, id_use_rs1_i, h1);
        s2  = m_fwd(id_rs2_i, id_use_rs2_i, h2);
        if (id_valid_i && !rdy && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (mem_stall_i) return;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (id_valid_i && rdy) begin
            m_pipe[0]  = '{v: 1, rd: id_rd_i, we: id_rd_we_i, ld: id_is_load_i};
            m_ex_valid = 1'b1;
            m_op       = id_alu_op_i;
            m_m1       = s1;
            m_m2       = s2;
            m_m3       = id_use_imm_i;
        end else begin
            m_pipe[0]  = '{v: 0, rd: 0, we: 0, ld: 0};
            m_ex_valid = 1'b0;
            m_op       = 5'd0;
            m_m1       = 2'b11;
            m_m2       = 2'b11;
            m_m3       = 1'b0;
        end
    endtask

    // ---- checking ---------------------------------------------------------
    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: check ready before the edge, advance model, check outputs.
    task automatic step(input string tag);
        #1;
        obs_ready = id_ready_o;
        chk({31'd0, obs_ready}, {31'd0, m_ready()}, {tag, ".ready"});
        @(posedge clk);
        m_clock();
        #1;
        chk({31'd0, ex_valid_o}, {31'd0, m_ex_valid}, {tag, ".ex_valid"});
        chk({27'd0, alu_op_o},   {27'd0, m_op},       {tag, ".alu_op"});
        chk({30'd0, mux1_o},     {30'd0, m_m1},       {tag, ".mux1"});
        chk({30'd0, mux2_o},     {30'd0, m_m2},       {tag, ".mux2"});
        chk({31'd0, mux3_o},     {31'd0, m_m3},       {tag, ".mux3"});
        chk(stall_cnt_o,         m_cnt,               {tag, ".stall_cnt"});
        @(negedge clk);
    endtask

    task automatic put(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic imm,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] op);
        id_valid_i   = v;
        id_rs1_i     = rs1;
        id_use_rs1_i = u1;
        id_rs2_i     = rs2;
        id_use_rs2_i = u2;
        id_use_imm_i = imm;
        id_rd_i      = rd;
        id_rd_we_i   = we;
        id_is_load_i = ld;
        id_alu_op_i  = op;
    endtask

    initial begin
        rst = 1'b1; mem_stall_i = 1'b0; flush_i = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        @(negedge clk);

        // Reset state
        step("reset");
        chk({30'd0, mux1_o}, 32'd3, "reset.mux1_zero");
        chk({31'd0, ex_valid_o}, 32'd0, "reset.ex_valid");
        rst = 1'b0;
        step("idle");

        // 1. Back-to-back dependency, then one independent op in between
        put(1, 1, 1, 2, 1, 0, 5, 1, 0, 5'd1);  step("t1.add_x5");
        put(1, 5, 1, 6, 1, 0, 8, 1, 0, 5'd2);  step("t1.use_x5");
        chk({30'd0, mux1_o}, 32'd2, "t1.mux1_exmem");
        put(1, 1, 1, 2, 1, 0, 5, 1, 0, 5'd3);  step("t1.add_x5b");
        put(1, 1, 1, 2, 1, 1, 9, 1, 0, 5'd4);  step("t1.indep");
        put(1, 5, 1, 2, 0, 0, 10, 1, 0, 5'd5); step("t1.use_x5b");
        chk({30'd0, mux1_o}, 32'd1, "t1.mux1_memwb");

        // 2. Load-use: exactly one bubble, then MEM/WB forward
        put(1, 1, 1, 2, 0, 1, 7, 1, 1, 5'd6);  step("t2.load_x7");
        put(1, 3, 1, 7, 1, 0, 11, 1, 0, 5'd7); step("t2.stall");
        chk({31'd0, obs_ready}, 32'd0, "t2.ready_low");
        chk({27'd0, alu_op_o}, 32'd0, "t2.bubble_op");
        chk({30'd0, mux2_o}, 32'd3, "t2.bubble_mux2");
        step("t2.retry");
        chk({31'd0, obs_ready}, 32'd1, "t2.ready_high");
        chk({30'd0, mux2_o}, 32'd1, "t2.mux2_memwb");
        chk(stall_cnt_o, 32'd1, "t2.stall_cnt");

        // 3. x0 as destination and source, including a load to x0
        put(1, 1, 1, 2, 1, 0, 0, 1, 1, 5'd8);  step("t3.load_x0");
        put(1, 0, 1, 2, 0, 0, 12, 1, 0, 5'd9); step("t3.use_x0");
        chk({31'd0, obs_ready}, 32'd1, "t3.no_stall");
        chk({30'd0, mux1_o}, 32'd3, "t3.mux1_zero");

        // 4. Two producers of x3: newest (EX) wins
        put(1, 1, 1, 2, 1, 0, 3, 1, 0, 5'd10); step("t4.prod_a");
        put(1, 1, 1, 2, 1, 0, 3, 1, 0, 5'd11); step("t4.prod_b");
        put(1, 3, 1, 2, 0, 0, 13, 1, 0, 5'd12); step("t4.use_x3");
        chk({30'd0, mux1_o}, 32'd2, "t4.mux1_newest");

        // 5. mem_stall held 3 cycles mid-stream
        put(1, 1, 1, 2, 1, 0, 4, 1, 0, 5'd13); step("t5.prod_x4");
        put(1, 4, 1, 2, 1, 0, 14, 1, 0, 5'd14);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t5.frozen");
            chk({27'd0, alu_op_o}, 32'd13, "t5.op_held");
        end
        chk(stall_cnt_o, 32'd4, "t5.stall_cnt");
        mem_stall_i = 1'b0;
        step("t5.release");
        chk({30'd0, mux1_o}, 32'd2, "t5.mux1_resume");

        // 6. flush during a load-use stall, then reset mid-stream
        put(1, 1, 1, 2, 1, 0, 9, 1, 1, 5'd15); step("t6.load_x9");
        put(1, 9, 1, 2, 1, 0, 15, 1, 0, 5'd16);
        flush_i = 1'b1;
        step("t6.flush");
        chk({31'd0, ex_valid_o}, 32'd0, "t6.ex_bubble");
        flush_i = 1'b0;
        step("t6.after_flush");
        chk({30'd0, mux1_o}, 32'd1, "t6.mux1_memwb");
        rst = 1'b1;
        step("t6.reset");
        chk({30'd0, mux2_o}, 32'd3, "t6.mux2_zero");
        chk(stall_cnt_o, 32'd0, "t6.cnt_cleared");
        rst = 1'b0;
        step("t6.post_reset");
        chk({30'd0, mux1_o}, 32'd0, "t6.no_stale_fwd");

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 500; i++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            put(($urandom_range(0, 4) != 0),
                5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 4)), ld ? 1'b1 : ($urandom_range(0, 3) != 0),
                ld, 5'($urandom_range(0, 31)));
            mem_stall_i = ($urandom_range(0, 9) == 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ex_hazard_ctrl
